// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, colours, ball state encoding and
// the fixed-width types used by the ball physics stage.
package pong_pkg;

   localparam int POSITION_REG_MAX   = 11;
   localparam int GRAPHICS_WIDTH     = 1280;
   localparam int GRAPHICS_HEIGHT    = 800;
   localparam int BORDER_WIDTH       = 50;
   localparam int BALL_RADIUS        = 10;
   localparam int BALL_SPEED         = 6;
   localparam int MAX_SPEED          = 12;
   localparam int PADDLE_WIDTH       = 20;
   localparam int PADDLE_LENGTH      = 200;
   localparam int SERVE_DELAY_FRAMES = 60;
   localparam int MISS_HOLD_FRAMES   = 30;

   localparam int POS_W       = POSITION_REG_MAX + 1;
   localparam int SPEED_W     = 4;
   localparam int FRAME_CNT_W = 7;

   typedef logic [POS_W-1:0]       pos_t;
   typedef logic [POS_W:0]         pos_ext_t;
   typedef logic [SPEED_W-1:0]     speed_t;
   typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      PLAY       = 2'd2,
      MISSED     = 2'd3
   } ball_state_t;

   // Limits on the ball centre, i.e. the border inset by the ball radius.
   localparam pos_t CENTRE_X = pos_t'(GRAPHICS_WIDTH / 2);
   localparam pos_t CENTRE_Y = pos_t'(GRAPHICS_HEIGHT / 2);
   localparam pos_t X_LO     = pos_t'(BORDER_WIDTH + BALL_RADIUS);
   localparam pos_t X_HI     = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS);
   localparam pos_t Y_LO     = pos_t'(BORDER_WIDTH + BALL_RADIUS);
   localparam pos_t Y_HI     = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS);

   localparam pos_ext_t PADDLE_FACE_OFFSET = pos_ext_t'(PADDLE_WIDTH + BALL_RADIUS);
   localparam pos_ext_t PADDLE_SPAN        = pos_ext_t'(PADDLE_LENGTH);

   localparam speed_t     SPEED_INIT  = speed_t'(BALL_SPEED);
   localparam speed_t     SPEED_CEIL  = speed_t'(MAX_SPEED);
   localparam frame_cnt_t SERVE_DELAY = frame_cnt_t'(SERVE_DELAY_FRAMES);
   localparam frame_cnt_t MISS_HOLD   = frame_cnt_t'(MISS_HOLD_FRAMES);

   localparam logic [11:0] COLOUR_BACKGROUND = 12'h000;
   localparam logic [11:0] COLOUR_BORDER     = 12'h888;
   localparam logic [11:0] COLOUR_PADDLE     = 12'h0F0;
   localparam logic [11:0] COLOUR_BALL       = 12'hFFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/ball_motion_axis_bounce.sv
// One axis of ball motion: step by speed, clamp at lo/hi and reverse direction
// when the step would cross a bound.
module axis_bounce
   import pong_pkg::*;
(
   input  logic [POS_W-1:0]   pos,
   input  logic               dir_pos,
   input  logic [SPEED_W-1:0] speed,
   input  logic [POS_W-1:0]   lo,
   input  logic [POS_W-1:0]   hi,
   output logic [POS_W-1:0]   next_pos,
   output logic               next_dir_pos
);

   pos_ext_t reach;
   pos_ext_t lo_guard;

   always_comb begin
      // NOTE: every output gets a default first so no branch can infer a latch.
      reach        = pos_ext_t'(pos) + pos_ext_t'(speed);
      lo_guard     = pos_ext_t'(lo) + pos_ext_t'(speed);
      next_pos     = pos;
      next_dir_pos = dir_pos;
      if (dir_pos) begin
         if (reach > pos_ext_t'(hi)) begin
            next_pos     = hi;
            next_dir_pos = 1'b0;
         end else begin
            next_pos = reach[POS_W-1:0];
         end
      end else begin
         // Guard compared before subtracting so pos never underflows.
         if (pos_ext_t'(pos) < lo_guard) begin
            next_pos     = lo;
            next_dir_pos = 1'b1;
         end else begin
            next_pos = pos - pos_t'(speed);
         end
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics for pong: serve delay, border/paddle bounces, miss
// detection. Optional feature macro: BALL_SPEEDUP_EN (speed +1 per paddle hit).
module ball_motion
   import pong_pkg::*;
(
   input  logic                      pixel_clock,
   input  logic                      reset,
   input  logic                      frame_tick,
   input  logic                      serve,
   input  logic [POSITION_REG_MAX:0] paddle_x,
   input  logic [POSITION_REG_MAX:0] paddle_y,
   output logic [POSITION_REG_MAX:0] ball_x,
   output logic [POSITION_REG_MAX:0] ball_y,
   output logic                      ball_visible,
   output logic                      hit_pulse,
   output logic                      miss_pulse,
   output logic [7:0]                miss_count
);

   ball_state_t state_q, state_d;
   logic        dx_pos, dy_pos;
   speed_t      speed;
   frame_cnt_t  frame_cnt;

   pos_t        x_d, y_d;
   logic        dx_d, dy_d;
   speed_t      speed_d;
   frame_cnt_t  cnt_d;
   logic        vis_d, hit_d, miss_d;
   logic [7:0]  miss_count_d;

   pos_t        x_next, y_next;
   logic        x_dir_next, y_dir_next;
   pos_ext_t    paddle_face;
   logic        paddle_hit, at_left_wall;

   // The x instance only supplies the right-border bounce; the left side is
   // resolved below by the paddle and miss rules.
   axis_bounce u_axis_x (
      .pos          (ball_x),
      .dir_pos      (dx_pos),
      .speed        (speed),
      .lo           (X_LO),
      .hi           (X_HI),
      .next_pos     (x_next),
      .next_dir_pos (x_dir_next)
   );

   axis_bounce u_axis_y (
      .pos          (ball_y),
      .dir_pos      (dy_pos),
      .speed        (speed),
      .lo           (Y_LO),
      .hi           (Y_HI),
      .next_pos     (y_next),
      .next_dir_pos (y_dir_next)
   );

   // Hit window written without subtraction: face <= x <= face + speed.
   assign paddle_face  = pos_ext_t'(paddle_x) + PADDLE_FACE_OFFSET;
   assign paddle_hit   = (pos_ext_t'(ball_x) >= paddle_face)
                      && (pos_ext_t'(ball_x) <= paddle_face + pos_ext_t'(speed))
                      && (pos_ext_t'(y_next) >= pos_ext_t'(paddle_y))
                      && (pos_ext_t'(y_next) <= pos_ext_t'(paddle_y) + PADDLE_SPAN);
   assign at_left_wall = pos_ext_t'(ball_x) < pos_ext_t'(X_LO) + pos_ext_t'(speed);

   always_comb begin
      state_d      = state_q;
      x_d          = ball_x;
      y_d          = ball_y;
      dx_d         = dx_pos;
      dy_d         = dy_pos;
      speed_d      = speed;
      cnt_d        = frame_cnt;
      vis_d        = ball_visible;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      miss_count_d = miss_count;

      unique case (state_q)
         IDLE: begin
            if (serve) begin
               state_d = SERVE_WAIT;
               cnt_d   = '0;
               speed_d = SPEED_INIT;
            end
         end

         SERVE_WAIT: begin
            if (frame_tick) begin
               cnt_d = frame_cnt + frame_cnt_t'(1);
               if (cnt_d == SERVE_DELAY) state_d = PLAY;
            end
         end

         PLAY: begin
            if (frame_tick) begin
               y_d  = y_next;
               dy_d = y_dir_next;
               if (dx_pos) begin
                  x_d  = x_next;
                  dx_d = x_dir_next;
               end else if (paddle_hit) begin
                  x_d   = paddle_face[POS_W-1:0];
                  dx_d  = 1'b1;
                  hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                  speed_d = (speed >= SPEED_CEIL) ? SPEED_CEIL : speed + speed_t'(1);
`endif
               end else if (at_left_wall) begin
                  state_d      = MISSED;
                  y_d          = ball_y;
                  dy_d         = dy_pos;
                  cnt_d        = '0;
                  vis_d        = 1'b0;
                  miss_d       = 1'b1;
                  miss_count_d = sat_inc8(miss_count);
               end else begin
                  x_d = ball_x - pos_t'(speed);
               end
            end
         end

         MISSED: begin
            if (frame_tick) begin
               cnt_d = frame_cnt + frame_cnt_t'(1);
               if (cnt_d == MISS_HOLD) begin
                  state_d = IDLE;
                  x_d     = CENTRE_X;
                  y_d     = CENTRE_Y;
                  dx_d    = 1'b0;
                  dy_d    = 1'b1;
                  speed_d = SPEED_INIT;
                  vis_d   = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clock) begin
      // NOTE: registers use <= so every one samples its pre-edge inputs.
      if (reset) begin
         state_q      <= IDLE;
         ball_x       <= CENTRE_X;
         ball_y       <= CENTRE_Y;
         dx_pos       <= 1'b0;
         dy_pos       <= 1'b1;
         speed        <= SPEED_INIT;
         frame_cnt    <= '0;
         ball_visible <= 1'b1;
         hit_pulse    <= 1'b0;
         miss_pulse   <= 1'b0;
         miss_count   <= '0;
      end else begin
         state_q      <= state_d;
         ball_x       <= x_d;
         ball_y       <= y_d;
         dx_pos       <= dx_d;
         dy_pos       <= dy_d;
         speed        <= speed_d;
         frame_cnt    <= cnt_d;
         ball_visible <= vis_d;
         hit_pulse    <= hit_d;
         miss_pulse   <= miss_d;
         miss_count   <= miss_count_d;
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed rally milestones plus random
// serve/tick/paddle/reset traffic against an integer reference model.
module tb_ball_motion;

   logic        pixel_clock = 1'b0;
   logic        reset, frame_tick, serve;
   logic [11:0] paddle_x, paddle_y;
   logic [11:0] ball_x, ball_y;
   logic        ball_visible, hit_pulse, miss_pulse;
   logic [7:0]  miss_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 pixel_clock = ~pixel_clock;

   ball_motion dut (
      .pixel_clock  (pixel_clock),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .serve        (serve),
      .paddle_x     (paddle_x),
      .paddle_y     (paddle_y),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .ball_visible (ball_visible),
      .hit_pulse    (hit_pulse),
      .miss_pulse   (miss_pulse),
      .miss_count   (miss_count)
   );

   // Reference model: plain integers, signed directions, phase numbers.
   localparam int PH_IDLE = 0, PH_WAIT = 1, PH_PLAY = 2, PH_MISSED = 3;
   int m_x, m_y, m_dx, m_dy, m_speed, m_phase, m_frames;
   int m_vis, m_hit, m_miss, m_misses;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE; m_x = 640; m_y = 400; m_dx = -1; m_dy = 1;
      m_speed = 6; m_frames = 0; m_vis = 1; m_hit = 0; m_miss = 0; m_misses = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit r);
      int nx, ny, ndx, ndy, face;
      if (r) begin
         model_reset();
         return;
      end
      m_hit  = 0;
      m_miss = 0;
      case (m_phase)
         PH_IDLE: if (s) begin m_phase = PH_WAIT; m_frames = 0; m_speed = 6; end
         PH_WAIT: if (t) begin
            m_frames++;
            if (m_frames == 60) m_phase = PH_PLAY;
         end
         PH_PLAY: if (t) begin
            ny = m_y + m_dy * m_speed; ndy = m_dy;
            if (m_dy < 0 && m_y < 60 + m_speed) begin ny = 60;  ndy = 1;  end
            if (m_dy > 0 && m_y + m_speed > 740) begin ny = 740; ndy = -1; end
            nx = m_x + m_dx * m_speed; ndx = m_dx;
            face = int'(paddle_x) + 20;
            if (m_dx > 0) begin
               if (nx > 1220) begin nx = 1220; ndx = -1; end
            end else if (m_x - 10 >= face && m_x - m_speed - 10 <= face &&
                         ny >= int'(paddle_y) && ny <= int'(paddle_y) + 200) begin
               nx = face + 10; ndx = 1; m_hit = 1;
`ifdef BALL_SPEEDUP_EN
               if (m_speed < 12) m_speed++;
`endif
            end else if (m_x < 60 + m_speed) begin
               m_phase = PH_MISSED; m_miss = 1; m_vis = 0; m_frames = 0;
               if (m_misses < 255) m_misses++;
               nx = m_x; ny = m_y; ndy = m_dy;
            end
            m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
         end
         PH_MISSED: if (t) begin
            m_frames++;
            if (m_frames == 30) begin
               m_phase = PH_IDLE; m_x = 640; m_y = 400; m_dx = -1; m_dy = 1;
               m_speed = 6; m_vis = 1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("ball_x", ball_x, m_x);
      check("ball_y", ball_y, m_y);
      check("ball_visible", ball_visible, m_vis);
      check("hit_pulse", hit_pulse, m_hit);
      check("miss_pulse", miss_pulse, m_miss);
      check("miss_count", miss_count, m_misses);
   endtask

   // Inputs change at the falling edge; outputs are sampled at the next one.
   task automatic cycle(input bit t, input bit s, input bit r);
      frame_tick = t; serve = s; reset = r;
      @(posedge pixel_clock);
      model_step(t, s, r);
      @(negedge pixel_clock);
      compare_all();
   endtask

   task automatic tick();
      repeat ($urandom_range(0, 2)) cycle(0, 0, 0);
      cycle(1, 0, 0);
   endtask

   initial begin
      bit done;
      reset = 1'b1; frame_tick = 1'b0; serve = 1'b0;
      paddle_x = 12'd110; paddle_y = 12'd500;
      model_reset();
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      check("reset_x", ball_x, 640);
      check("reset_y", ball_y, 400);
      check("reset_visible", ball_visible, 1);
      check("reset_miss_count", miss_count, 0);

      repeat (5) tick();
      check("idle_hold_x", ball_x, 640);
      check("idle_hold_y", ball_y, 400);

      cycle(0, 1, 0);
      repeat (60) tick();
      check("serve_wait_x", ball_x, 640);
      tick();
      check("play1_x", ball_x, 634);
      check("play1_y", ball_y, 406);

      repeat (55) tick();
      tick();
      check("play57_y_clamp", ball_y, 740);
      check("play57_x", ball_x, 298);
      tick();
      check("play58_y", ball_y, 734);
      check("play58_x", ball_x, 292);

      repeat (25) tick();
      tick();
      check("play84_x", ball_x, 140);
      check("play84_y", ball_y, 578);
      check("play84_hit", hit_pulse, 1);
      cycle(0, 0, 0);
      check("hit_one_cycle", hit_pulse, 0);
      tick();
`ifdef BALL_SPEEDUP_EN
      check("play85_x", ball_x, 147);
`else
      check("play85_x", ball_x, 146);
`endif

      // Paddle moved out of reach: the rally must end in a miss.
      paddle_x = 12'd3000; paddle_y = 12'd110;
      done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         tick();
         if (m_phase == PH_MISSED) done = 1;
      end
      check("miss_reached", done, 1);
      check("miss_pulse_hi", miss_pulse, 1);
      check("miss_hidden", ball_visible, 0);
      check("miss_count_1", miss_count, 1);
      cycle(0, 0, 0);
      check("miss_one_cycle", miss_pulse, 0);
      repeat (30) tick();
      check("recentre_x", ball_x, 640);
      check("recentre_y", ball_y, 400);
      check("recentre_visible", ball_visible, 1);

      // Saturation: 256 further misses with a tick on every cycle.
      for (int r = 0; r < 256; r++) begin
         cycle(0, 1, 0);
         done = 0;
         for (int i = 0; i < 400 && !done; i++) begin
            cycle(1, 0, 0);
            if (m_phase == PH_IDLE) done = 1;
         end
         if (!done) begin
            check("rally_timeout", 0, 1);
            break;
         end
      end
      check("miss_count_sat", miss_count, 255);

      // Reset asserted together with a tick in the middle of play.
      cycle(0, 1, 0);
      repeat (65) cycle(1, 0, 0);
      cycle(1, 0, 1);
      check("midreset_x", ball_x, 640);
      check("midreset_y", ball_y, 400);
      check("midreset_hit", hit_pulse, 0);
      check("midreset_miss", miss_pulse, 0);
      check("midreset_count", miss_count, 0);
      repeat (3) tick();
      check("midreset_idle_x", ball_x, 640);

      // Random traffic; paddle often placed near the ball to provoke hits.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            paddle_x = 12'($urandom_range(60, 200));
            if ($urandom_range(0, 2) == 0)
               paddle_y = 12'((m_y > 100) ? m_y - 100 : 0);
            else
               paddle_y = 12'($urandom_range(0, 600));
         end
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 999) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
